// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 frame parser.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HUM_I = 3'd1,
    HUM_D = 3'd2,
    TMP_I = 3'd3,
    TMP_D = 3'd4,
    CHK   = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
  localparam int         FRAME_LEN     = 6;

  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
  } reading_t;

  // DHT11 checksum: 8-bit wrapping sum of the four data bytes
  function automatic logic [7:0] frame_sum(reading_t r);
    logic [7:0] s;
    s = r.hum_int + r.hum_dec + r.temp_int + r.temp_dec;
    return s;
  endfunction

endpackage

// File: rtl/dht11_frame_parser_if.sv
// Byte-in / reading-out bundle between the UART receiver, the parser and its consumers.
interface dht11_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       frame_valid;
  logic       chksum_err;
  logic       timeout_err;
  logic [7:0] err_count;
  logic       busy;

  modport master (
    output rx_data, rx_done,
    input  hum_int, hum_dec, temp_int, temp_dec,
    input  frame_valid, chksum_err, timeout_err, err_count, busy
  );

  modport slave (
    input  rx_data, rx_done,
    output hum_int, hum_dec, temp_int, temp_dec,
    output frame_valid, chksum_err, timeout_err, err_count, busy
  );
endinterface

// File: rtl/dht11_timeout_ctr.sv
// Inter-byte watchdog: counts while enabled, flags expiry at TIMEOUT_CYCLES-1.
module dht11_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 20_000,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/dht11_frame_parser.sv
// Assembles sync + 4 data + checksum byte frames from the UART stream and latches valid readings.
module dht11_frame_parser
  import dht11_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 20_000,
  parameter int         CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dht11_frame_parser_if.slave  bus
);

  state_t     state;
  reading_t   frame_buf;
  reading_t   reading;
  logic       frame_valid_r;
  logic       chksum_err_r;
  logic       timeout_err_r;
  logic [7:0] err_count_r;
  logic       expire;

  dht11_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.rx_done || (state == IDLE)),
    .enable (state != IDLE),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      frame_buf     <= '0;
      reading       <= '0;
      frame_valid_r <= 1'b0;
      chksum_err_r  <= 1'b0;
      timeout_err_r <= 1'b0;
      err_count_r   <= '0;
    end else begin
      frame_valid_r <= 1'b0;
      chksum_err_r  <= 1'b0;
      timeout_err_r <= 1'b0;
      // An arriving byte takes priority over a simultaneous timeout expiry
      if (bus.rx_done) begin
        case (state)
          IDLE: begin
            if (bus.rx_data == SYNC_BYTE) state <= HUM_I;
          end
          HUM_I: begin
            frame_buf.hum_int <= bus.rx_data;
            state             <= HUM_D;
          end
          HUM_D: begin
            frame_buf.hum_dec <= bus.rx_data;
            state             <= TMP_I;
          end
          TMP_I: begin
            frame_buf.temp_int <= bus.rx_data;
            state              <= TMP_D;
          end
          TMP_D: begin
            frame_buf.temp_dec <= bus.rx_data;
            state              <= CHK;
          end
          CHK: begin
            if (bus.rx_data == frame_sum(frame_buf)) begin
              reading       <= frame_buf;
              frame_valid_r <= 1'b1;
            end else begin
              chksum_err_r <= 1'b1;
              if (err_count_r != 8'hFF) err_count_r <= err_count_r + 8'd1;
            end
            frame_buf <= '0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (expire) begin
        timeout_err_r <= 1'b1;
        if (err_count_r != 8'hFF) err_count_r <= err_count_r + 8'd1;
        frame_buf <= '0;
        state     <= IDLE;
      end
    end
  end

  assign bus.hum_int     = reading.hum_int;
  assign bus.hum_dec     = reading.hum_dec;
  assign bus.temp_int    = reading.temp_int;
  assign bus.temp_dec    = reading.temp_dec;
  assign bus.frame_valid = frame_valid_r;
  assign bus.chksum_err  = chksum_err_r;
  assign bus.timeout_err = timeout_err_r;
  assign bus.err_count   = err_count_r;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_dht11_frame_parser.sv
// Scoreboard bench for dht11_frame_parser: byte-level frame model predicts every output event.
module tb_dht11_frame_parser;

  localparam int T = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dht11_frame_parser_if bus();

  dht11_frame_parser #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 frame_valid, 1 chksum_err, 2 timeout_err
    int unsigned at;
    logic [7:0]  hi, hd, ti, td, ec;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit          in_frame = 0;
  int          nb = 0;
  int          fb[4];
  int unsigned last_cyc = 0;
  logic [7:0]  m_hi = 0, m_hd = 0, m_ti = 0, m_td = 0, m_ec = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_evt(int kind, int unsigned at);
    exp_t e;
    if (kind != 0 && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
    e.kind = kind; e.at = at;
    e.hi = m_hi; e.hd = m_hd; e.ti = m_ti; e.td = m_td; e.ec = m_ec;
    sb.push_back(e);
  endfunction

  // A frame in progress dies if the next byte comes more than T cycles after the previous one
  function automatic void model_gap(int unsigned next_drive);
    if (in_frame && (next_drive - last_cyc) > T) begin
      push_evt(2, last_cyc + 1 + T);
      in_frame = 0;
    end
  endfunction

  function automatic void model_byte(int b, int unsigned drive);
    model_gap(drive);
    if (!in_frame) begin
      if (b == 'hAA) begin in_frame = 1; nb = 0; end
    end else if (nb < 4) begin
      fb[nb] = b;
      nb++;
    end else begin
      if (b == (fb[0] + fb[1] + fb[2] + fb[3]) % 256) begin
        m_hi = 8'(fb[0]); m_hd = 8'(fb[1]); m_ti = 8'(fb[2]); m_td = 8'(fb[3]);
        push_evt(0, drive + 1);
      end else begin
        push_evt(1, drive + 1);
      end
      in_frame = 0;
    end
    last_cyc = drive;
  endfunction

  // called at a negedge; leaves at the next negedge
  task automatic send(int b);
    model_byte(b, cyc);
    bus.rx_data = 8'(b);
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic idle(int n);
    model_gap(cyc + n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(int hi, int hd, int ti, int td, bit bad, int gapmax);
    int cs;
    int d[6];
    cs = (hi + hd + ti + td) % 256;
    if (bad) cs = cs ^ int'($urandom_range(1, 255));
    d[0] = 'hAA; d[1] = hi; d[2] = hd; d[3] = ti; d[4] = td; d[5] = cs;
    for (int i = 0; i < 6; i++) begin
      send(d[i]);
      if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_hum_int", bus.hum_int, 0);
    check("rst_hum_dec", bus.hum_dec, 0);
    check("rst_temp_int", bus.temp_int, 0);
    check("rst_temp_dec", bus.temp_dec, 0);
    check("rst_err_count", bus.err_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pulses", {bus.frame_valid, bus.chksum_err, bus.timeout_err}, 0);
    check("rst_pending_events", sb.size(), 0);
    sb.delete();
    in_frame = 0; nb = 0;
    m_hi = 0; m_hd = 0; m_ti = 0; m_td = 0; m_ec = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // monitor
  initial begin
    exp_t e;
    int n;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        n = int'(bus.frame_valid) + int'(bus.chksum_err) + int'(bus.timeout_err);
        if (n > 0) begin
          check("pulse_exclusive", (n > 1), 0);
          if (sb.size() == 0) begin
            check("unexpected_event", {bus.frame_valid, bus.chksum_err, bus.timeout_err}, 0);
          end else begin
            e = sb.pop_front();
            check("event_kind", bus.timeout_err ? 2 : (bus.chksum_err ? 1 : 0), e.kind);
            check("event_cycle", cyc, e.at);
            check("hum_int", bus.hum_int, e.hi);
            check("hum_dec", bus.hum_dec, e.hd);
            check("temp_int", bus.temp_int, e.ti);
            check("temp_dec", bus.temp_dec, e.td);
            check("err_count", bus.err_count, e.ec);
            check("busy_after_event", bus.busy, 0);
          end
        end else if (sb.size() > 0 && cyc > sb[0].at) begin
          check("missed_event_cycle", cyc, sb[0].at);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // nominal, bad checksum, wrap, leading garbage with in-frame sync
    send_frame('h3C, 'h00, 'h05, 'h03, 0, 0);
    idle(3);
    send_frame('h3C, 'h00, 'h05, 'h03, 1, 0);
    idle(3);
    send_frame('hFF, 'h01, 'h00, 'h00, 0, 0);
    idle(3);
    send('h12); send('h55);
    send_frame('hAA, 'h00, 'h10, 'h02, 0, 0);
    idle(3);

    // timeout, then recovery; busy visible mid-frame
    send('hAA);
    check("busy_mid_frame", bus.busy, 1);
    send('h3C);
    idle(T + 5);
    check("busy_after_timeout", bus.busy, 0);
    send_frame('h3C, 'h00, 'h05, 'h03, 0, 0);
    idle(3);

    // byte landing exactly on the expiry cycle wins; one cycle later loses
    send('hAA); idle(T - 1); send('h20); idle(T - 1); send('h01);
    send('h19); send('h02); send('h3C);
    idle(3);
    send('hAA); idle(T); send('h20);
    idle(3);

    // reset mid-frame
    send('hAA); send('h3C); send('h00);
    do_reset();
    send_frame('h3C, 'h00, 'h05, 'h03, 0, 0);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        send_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 3);
      end else if (r < 7) begin
        send_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1, 2);
      end else if (r == 7) begin
        send(int'($urandom_range(0, 255)));
      end else if (r == 8) begin
        send('hAA);
        for (int k = 0; k < int'($urandom_range(0, 4)); k++) send(int'($urandom_range(0, 255)));
        idle(T - 1 + int'($urandom_range(0, 2)));
      end else begin
        idle(int'($urandom_range(1, 10)));
      end
    end
    idle(T + 5);

    // saturate err_count
    for (int i = 0; i < 260; i++) send_frame('h01, 'h02, 'h03, 'h04, 1, 0);
    send('hAA);
    idle(T + 5);
    check("err_count_saturated", bus.err_count, 8'hFF);
    send_frame('h11, 'h22, 'h33, 'h44, 0, 1);
    idle(5);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
